sum16_result_collector: RTL and testbench

// - Downstream stage of the 16-bit pipelined KPG prefix adder. Tracks each operand pair issued into the adder.
// - Captures the adder's 17-bit sum exactly when that pair's result emerges, and buffers it in a small FIFO.
// - Presents results on a valid/ready output with an optional tag. Credit-based in_ready gating guarantees no result is ever lost.

---
 rtl/adder_pl_pkg.sv | 11 +
 rtl/result_fifo.sv | 39 +++
 rtl/sum16_result_collector.sv | 65 ++++++
 tb/tb_sum16_result_collector.sv | 115 +++++++++++
 4 files changed

// File: rtl/adder_pl_pkg.sv
// adder_pl_pkg: shared widths, latency and result record for the pipelined adder and its collector
package adder_pl_pkg;
  localparam int SUM_W = 17;
  localparam int OPW = 16;
  localparam int ADD_LAT = 4;
  localparam int TAG_W = 4;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SUM_W-1:0] sum;
  } result_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: DEPTH-entry first-word-fall-through FIFO; ports clk, rst, push/push_data, pop, head, count, full, empty
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic rd, wr;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd = pop && !empty;
  // a simultaneous pop frees the slot the push needs
  assign wr = push && (!full || rd);
  assign head = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) mem[wp] <= push_data;
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/sum16_result_collector.sv
// sum16_result_collector: tracks adder issues with a {valid,tag} delay line, captures sums into a FIFO, credit-gates in_ready
// ports: clk, rst, in_valid/in_ready/in_tag (issue side), sum_in (adder output),
//        out_valid/out_ready/out_sum/out_carry/out_tag (result side), inflight, ovf_err (sticky)
module sum16_result_collector
  import adder_pl_pkg::*;
#(
  parameter int ADD_LAT = adder_pl_pkg::ADD_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = adder_pl_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [16:0]      sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       inflight,
  output logic             ovf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W = TAG_W + SUM_W;
  logic [ADD_LAT-1:0] dv;
  logic [TAG_W-1:0] dt [ADD_LAT];
  logic [CW-1:0] count;
  logic [W-1:0] head;
  logic full, empty, issue, push, pop;
  assign issue = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign push = dv[ADD_LAT-1];
  assign out_valid = !empty;
  // every buffered or in-flight result already owns a FIFO slot, so captures cannot overflow
  assign in_ready = (int'(count) + int'(inflight)) < DEPTH;
  assign out_sum = head[15:0];
  assign out_carry = head[16];
  assign out_tag = head[W-1:SUM_W];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dv <= '0;
      for (int i = 0; i < ADD_LAT; i++) dt[i] <= '0;
      inflight <= '0;
      ovf_err <= 1'b0;
    end else begin
      dv <= {dv[ADD_LAT-2:0], issue};
      dt[0] <= in_tag;
      for (int i = 1; i < ADD_LAT; i++) dt[i] <= dt[i-1];
      inflight <= inflight + 3'(issue) - 3'(dv[ADD_LAT-1]);
      if (push && full && !pop) ovf_err <= 1'b1;
    end
  result_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data({dt[ADD_LAT-1], sum_in}),
    .pop(pop),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_sum16_result_collector.sv
// tb_sum16_result_collector: directed and random stimulus against an outstanding-operation queue model
module tb_sum16_result_collector;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_tag = '0;
  logic [15:0] a = '0, b = '0;
  logic k = 1'b0;
  logic [16:0] sum_in;
  logic in_ready, out_valid, out_carry, ovf_err;
  logic [15:0] out_sum;
  logic [3:0] out_tag;
  logic [2:0] inflight;
  logic [16:0] p [4];
  typedef struct {int c; logic [3:0] t; logic [16:0] s;} item_t;
  item_t q[$];
  int cyc = 0, checks = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    p[0] <= {1'b0, a} + {1'b0, b} + {16'b0, k};
    for (int i = 1; i < 4; i++) p[i] <= p[i-1];
  end
  assign sum_in = p[3];
  sum16_result_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .sum_in(sum_in), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_tag(out_tag), .inflight(inflight), .ovf_err(ovf_err)
  );
  task automatic chk(input string n, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", n, o, e, cyc);
    end
  endtask
  task automatic tick();
    bit ev, iss, pp;
    int inf;
    item_t it;
    inf = 0;
    foreach (q[i]) if (cyc < q[i].c + 4) inf++;
    ev = q.size() > 0 && cyc >= q[0].c + 4;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 4));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("inflight", 32'(inflight), 32'(inf));
    chk("ovf_err", 32'(ovf_err), 32'(0));
    if (ev) begin
      chk("out_sum", 32'(out_sum), 32'(q[0].s[15:0]));
      chk("out_carry", 32'(out_carry), 32'(q[0].s[16]));
      chk("out_tag", 32'(out_tag), 32'(q[0].t));
    end
    iss = in_valid && q.size() < 4;
    pp = out_ready && ev;
    it = '{cyc + 1, in_tag, 17'(a) + 17'(b) + 17'(k)};
    @(posedge clk);
    #1;
    cyc++;
    if (pp) void'(q.pop_front());
    if (iss) q.push_back(it);
  endtask
  task automatic op(input logic v, input logic [3:0] t, input logic r);
    in_valid = v;
    in_tag = t;
    out_ready = r;
    a = 16'($urandom);
    b = 16'($urandom);
    k = 1'($urandom);
    tick();
  endtask
  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    q.delete();
  endtask
  initial begin
    #1;
    reset_pulse();
    for (int i = 0; i < 10; i++) op(1'b0, 4'd0, 1'b0);
    chk("rst_out_sum", 32'(out_sum), 32'(0));
    chk("rst_out_carry", 32'(out_carry), 32'(0));
    chk("rst_out_tag", 32'(out_tag), 32'(0));
    in_valid = 1'b1; in_tag = 4'd3; a = 16'hFFFF; b = 16'h0001; k = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("single_not_early", 32'(out_valid), 32'(0));
    tick();
    chk("single_valid", 32'(out_valid), 32'(1));
    chk("single_sum", 32'(out_sum), 32'(16'h0000));
    chk("single_carry", 32'(out_carry), 32'(1));
    chk("single_tag", 32'(out_tag), 32'(3));
    op(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) op(1'b1, 4'(i), 1'b1);
    for (int i = 0; i < 12; i++) op(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) op(1'b1, 4'(i), 1'b0);
    chk("full_ready_low", 32'(in_ready), 32'(0));
    op(1'b1, 4'd9, 1'b1);
    for (int i = 0; i < 6; i++) op(1'b1, 4'(10 + i), 1'b0);
    for (int i = 0; i < 3; i++) op(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) op(1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 2; i++) op(1'b1, 4'(8 + i), 1'b0);
    reset_pulse();
    for (int i = 0; i < 6; i++) op(1'b0, 4'd0, 1'b1);
    chk("post_rst_valid", 32'(out_valid), 32'(0));
    op(1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++) op(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) op(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 400; i++) op(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) op(1'b0, 4'd0, 1'b1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
